// File: rtl/caixa_pkg.sv
// Shared types and constants for the tank controller: state encoding, default
// parameters and filtered-level decode values (bit order {H, M, L}).
package caixa_pkg;

    typedef enum logic [1:0] {
        REPOUSO  = 2'd0,
        ENCHENDO = 2'd1,
        REGANDO  = 2'd2,
        FALHA    = 2'd3
    } estado_t;

    localparam int DEB_CYCLES_DEF = 8;
    localparam int FILL_MAX_DEF   = 1000;

    localparam logic [2:0] NIVEL_CRITICO = 3'b000;
    localparam logic [2:0] NIVEL_BAIXO   = 3'b001;
    localparam logic [2:0] NIVEL_MEDIO   = 3'b011;
    localparam logic [2:0] NIVEL_CHEIO   = 3'b111;

    // A wetted sensor above a dry one is physically impossible.
    function automatic logic sensor_fault(input logic [2:0] nivel);
        return (nivel[1] & ~nivel[0]) | (nivel[2] & ~nivel[1]);
    endfunction

endpackage

// File: rtl/filtro_sensor.sv
// Sensor conditioner: 2-flop synchronizer followed by a debounce counter.
// Latency: 2 + DEB_CYCLES cycles from a stable raw edge to filt_o; no backpressure.
// Any sample matching the current filtered value restarts the count.
module filtro_sensor #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q,  filt_d;
    logic [7:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/controle_caixa.sv
// Water tank fill / irrigation controller with filtered level sensors and fault state.
// Latency: registered Moore outputs, one edge after the filtered level or request; no backpressure.
// Optional fill watchdog enabled by macro CAIXA_FILL_WATCHDOG_EN.
module controle_caixa
    import caixa_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int FILL_MAX   = FILL_MAX_DEF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       Req_Rega,
    input  logic       Clr_Erro,
    output logic       Ve,
    output logic       Bomba,
    output logic       Al,
    output logic       ERRO,
    output logic [1:0] Estado
);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || FILL_MAX < 1 || FILL_MAX > 65535) begin : g_param_check
        $error("controle_caixa: DEB_CYCLES or FILL_MAX out of range");
    end

    logic f_h, f_m, f_l;

    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_h (
        .clk(Clk), .rst_n(Rst_n), .raw_i(H), .filt_o(f_h)
    );
    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_m (
        .clk(Clk), .rst_n(Rst_n), .raw_i(M), .filt_o(f_m)
    );
    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_l (
        .clk(Clk), .rst_n(Rst_n), .raw_i(L), .filt_o(f_l)
    );

    logic [2:0] nivel;
    logic       falha_sensor, critico, precisa_encher, cheio, tem_agua;

    assign nivel          = {f_h, f_m, f_l};
    assign falha_sensor   = sensor_fault(nivel);
    assign critico        = (nivel == NIVEL_CRITICO);
    assign precisa_encher = critico | (nivel == NIVEL_BAIXO);
    assign cheio          = (nivel == NIVEL_CHEIO);
    assign tem_agua       = cheio | (nivel == NIVEL_MEDIO);

    estado_t state_q, state_d;
    logic    ve_q, ve_d, bomba_q, bomba_d, al_q, al_d, erro_q, erro_d;
    logic    timeout;

`ifdef CAIXA_FILL_WATCHDOG_EN
    localparam logic [15:0] FILL_LAST = 16'(FILL_MAX - 1);

    logic [15:0] fill_cnt_q, fill_cnt_d;

    // Held at zero outside ENCHENDO, so every fill starts counting from zero.
    always_comb begin
        fill_cnt_d = '0;
        if (state_q == ENCHENDO) begin
            fill_cnt_d = fill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            fill_cnt_q <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
        end
    end

    assign timeout = (state_q == ENCHENDO) && (fill_cnt_q == FILL_LAST) && !cheio;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REPOUSO: begin
                if (falha_sensor)                state_d = FALHA;
                else if (precisa_encher)         state_d = ENCHENDO;
                else if (Req_Rega && tem_agua)   state_d = REGANDO;
            end
            ENCHENDO: begin
                if (falha_sensor || timeout)     state_d = FALHA;
                else if (cheio)                  state_d = REPOUSO;
            end
            REGANDO: begin
                if (falha_sensor)                state_d = FALHA;
                else if (precisa_encher)         state_d = ENCHENDO;
                else if (!Req_Rega)              state_d = REPOUSO;
            end
            FALHA: begin
                if (Clr_Erro && !falha_sensor)   state_d = REPOUSO;
            end
            default:                             state_d = REPOUSO;
        endcase

        // Outputs follow the next state so they flip on the same edge as Estado.
        ve_d    = (state_d == ENCHENDO);
        bomba_d = (state_d == REGANDO);
        erro_d  = (state_d == FALHA);
        al_d    = (state_d == FALHA) | critico;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= REPOUSO;
            ve_q    <= 1'b0;
            bomba_q <= 1'b0;
            al_q    <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ve_q    <= ve_d;
            bomba_q <= bomba_d;
            al_q    <= al_d;
            erro_q  <= erro_d;
        end
    end

    assign Ve     = ve_q;
    assign Bomba  = bomba_q;
    assign Al     = al_q;
    assign ERRO   = erro_q;
    assign Estado = state_q;

endmodule

// File: tb/tb_controle_caixa.sv
// Bench for controle_caixa: directed scenarios plus random sensor/request traffic,
// checked every cycle against a sample-history model of the filters and the state rules.
module tb_controle_caixa;

    localparam int DEB  = 4;
    localparam int FMAX = 50;

    logic       Clk = 1'b0;
    logic       Rst_n, H, M, L, Req_Rega, Clr_Erro;
    logic       Ve, Bomba, Al, ERRO;
    logic [1:0] Estado;

    always #5 Clk = ~Clk;

    controle_caixa #(.DEB_CYCLES(DEB), .FILL_MAX(FMAX)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .H(H), .M(M), .L(L),
        .Req_Rega(Req_Rega), .Clr_Erro(Clr_Erro),
        .Ve(Ve), .Bomba(Bomba), .Al(Al), .ERRO(ERRO), .Estado(Estado)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    // Model: state as integer, filtered bits, raw-sample history per sensor (L, M, H).
    int m_state = 0;
    int m_enc   = 0;
    bit mf   [3];
    bit hist [3][DEB+2];
    int e_ve = 0, e_bomba = 0, e_al = 0, e_erro = 0;

    function automatic bit wd_en();
`ifdef CAIXA_FILL_WATCHDOG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs held across that edge.
    task automatic model_step();
        bit raw [3];
        bit l, m, h, flt, crit, enche, full, agua, tmo, all_diff;
        int nxt;
        raw[0] = L; raw[1] = M; raw[2] = H;
        if (!Rst_n) begin
            m_state = 0; m_enc = 0;
            for (int s = 0; s < 3; s++) begin
                mf[s] = 1'b0;
                for (int i = 0; i < DEB + 2; i++) hist[s][i] = 1'b0;
            end
            e_ve = 0; e_bomba = 0; e_al = 0; e_erro = 0;
        end else begin
            l = mf[0]; m = mf[1]; h = mf[2];
            flt   = (m && !l) || (h && !m);
            crit  = !l && !m && !h;
            enche = crit || (l && !m && !h);
            full  = l && m && h;
            agua  = full || (l && m && !h);
            tmo   = wd_en() && (m_state == 1) && (m_enc == FMAX) && !full;
            nxt = m_state;
            case (m_state)
                0: nxt = flt ? 3 : enche ? 1 : (Req_Rega && agua) ? 2 : 0;
                1: nxt = (flt || tmo) ? 3 : full ? 0 : 1;
                2: nxt = flt ? 3 : enche ? 1 : !Req_Rega ? 0 : 2;
                default: nxt = (Clr_Erro && !flt) ? 0 : 3;
            endcase
            m_enc   = (nxt == 1) ? ((m_state == 1) ? m_enc + 1 : 1) : 0;
            m_state = nxt;
            e_ve    = (nxt == 1);
            e_bomba = (nxt == 2);
            e_erro  = (nxt == 3);
            e_al    = (nxt == 3) || crit;
            // Filtered bit flips once the DEB samples that have cleared the
            // synchronizer all disagree with it.
            for (int s = 0; s < 3; s++) begin
                all_diff = 1'b1;
                for (int i = 1; i <= DEB; i++) if (hist[s][i] == mf[s]) all_diff = 1'b0;
                if (all_diff) mf[s] = !mf[s];
                for (int i = 0; i < DEB + 1; i++) hist[s][i] = hist[s][i+1];
                hist[s][DEB+1] = raw[s];
            end
        end
    endtask

    task automatic compare_all();
        check("estado", int'(Estado), m_state);
        check("ve",     int'(Ve),     e_ve);
        check("bomba",  int'(Bomba),  e_bomba);
        check("al",     int'(Al),     e_al);
        check("erro",   int'(ERRO),   e_erro);
        check("ve_bomba_excl", int'(Ve & Bomba), 0);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        model_step();
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        Rst_n = 1'b0; H = 1'b0; M = 1'b0; L = 1'b0; Req_Rega = 1'b0; Clr_Erro = 1'b0;
        ticks(3);
        check("rst_estado", int'(Estado), 0);
        check("rst_ve",     int'(Ve),     0);
        check("rst_bomba",  int'(Bomba),  0);
        check("rst_al",     int'(Al),     0);
        check("rst_erro",   int'(ERRO),   0);

        // Empty tank after reset: fill with alarm on the first edge.
        Rst_n = 1'b1;
        tick();
        check("post_rst_estado", int'(Estado), 1);
        check("post_rst_ve",     int'(Ve),     1);
        check("post_rst_al",     int'(Al),     1);

        L = 1'b1; ticks(10);
        M = 1'b1; ticks(10);
        H = 1'b1; ticks(6);
        check("fill_ve_before", int'(Ve), 1);
        tick();
        check("fill_ve_after",     int'(Ve),     0);
        check("fill_estado_after", int'(Estado), 0);

        Req_Rega = 1'b1; tick();
        check("rega_estado", int'(Estado), 2);
        check("rega_bomba",  int'(Bomba),  1);
        H = 1'b0; ticks(10);
        M = 1'b0; ticks(6);
        check("rega_hold_bomba", int'(Bomba), 1);
        tick();
        check("drop_estado", int'(Estado), 1);
        check("drop_ve",     int'(Ve),     1);
        check("drop_bomba",  int'(Bomba),  0);

        Req_Rega = 1'b0; M = 1'b1; H = 1'b1; ticks(10);
        check("refull_estado", int'(Estado), 0);

        // Three-cycle glitch on L must be absorbed by the debouncer.
        L = 1'b0; ticks(3);
        L = 1'b1; ticks(12);
        check("glitch_estado", int'(Estado), 0);
        check("glitch_al",     int'(Al),     0);

        L = 1'b0; H = 1'b0; ticks(10);
        check("fault_estado", int'(Estado), 3);
        check("fault_erro",   int'(ERRO),   1);
        check("fault_al",     int'(Al),     1);
        Clr_Erro = 1'b1; tick(); Clr_Erro = 1'b0;
        check("clr_ignored", int'(Estado), 3);
        ticks(2);
        M = 1'b0; ticks(10);
        check("fault_hold", int'(Estado), 3);
        Clr_Erro = 1'b1; tick(); Clr_Erro = 1'b0;
        check("clr_ok", int'(Estado), 0);
        tick();
        check("refill_estado", int'(Estado), 1);

        // Low level only: fill never completes.
        L = 1'b1; ticks(FMAX - 1);
        check("wd_before", int'(Estado), 1);
        tick();
        check("wd_edge", int'(Estado), wd_en() ? 3 : 1);
        M = 1'b1; H = 1'b1; ticks(10);
        Clr_Erro = 1'b1; tick(); Clr_Erro = 1'b0;
        ticks(2);
        check("wd_recover", int'(Estado), 0);

        Req_Rega = 1'b1; ticks(2);
        check("pre_rst_estado", int'(Estado), 2);
        Rst_n = 1'b0; tick();
        check("midrst_estado", int'(Estado), 0);
        check("midrst_bomba",  int'(Bomba),  0);
        check("midrst_ve",     int'(Ve),     0);
        check("midrst_al",     int'(Al),     0);
        check("midrst_erro",   int'(ERRO),   0);
        Rst_n = 1'b1; Req_Rega = 1'b0;

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) L = !L;
            if ($urandom_range(0, 11) == 0) M = !M;
            if ($urandom_range(0, 11) == 0) H = !H;
            if ($urandom_range(0, 19) == 0) Req_Rega = !Req_Rega;
            Clr_Erro = ($urandom_range(0, 15) == 0);
            Rst_n    = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/controle_caixa.md
CONTROLE_CAIXA -- requirements
Module: controle_caixa

Interface
REQ-001 Parameter DEB_CYCLES, default 8: consecutive equal samples a synchronized sensor bit must hold before its filtered value changes; legal range 2..255.
REQ-002 Parameter FILL_MAX, default 1000: maximum Clk cycles allowed in ENCHENDO before a fill-timeout fault; legal range 1..65535.
REQ-003 Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  synchronous, active-low reset.
REQ-005 H, M, L  input  1 each  raw, asynchronous tank level sensors (high, medium, low; 1 = water present).
REQ-006 Req_Rega  input  1  level-sensitive irrigation request from the scheduler.
REQ-007 Clr_Erro  input  1  single-cycle fault acknowledge.
REQ-008 Ve  output  1  inlet valve open.
REQ-009 Bomba  output  1  irrigation pump on.
REQ-010 Al  output  1  alarm.
REQ-011 ERRO  output  1  fault indicator.
REQ-012 Estado  output  2  current state encoding.

Function
REQ-013 Each sensor SHALL pass a 2-flop synchronizer, then a debounce counter; its filtered bit SHALL update only after DEB_CYCLES consecutive synchronized samples differ from the current filtered value; any matching sample SHALL clear the counter.
REQ-014 Raw sensor edge to filtered edge latency SHALL be exactly 2 + DEB_CYCLES cycles for a stable input.
REQ-015 Filtered levels: critical = ~L & ~M & ~H; low = L & ~M & ~H; medium = L & M & ~H; full = L & M & H; sensor fault = (M & ~L) | (H & ~M).
REQ-016 States: REPOUSO=0, ENCHENDO=1, REGANDO=2, FALHA=3; Estado SHALL equal the state register.
REQ-017 Transition priority per cycle: sensor fault or fill timeout -> FALHA first, then fill, then irrigation.
REQ-018 REPOUSO -> ENCHENDO when level is critical or low; REPOUSO -> REGANDO when Req_Rega=1 and level is medium or full.
REQ-019 ENCHENDO -> REPOUSO when level is full; Req_Rega SHALL be ignored during ENCHENDO.
REQ-020 REGANDO -> REPOUSO when Req_Rega=0; REGANDO -> ENCHENDO when level drops to low or critical, regardless of Req_Rega.
REQ-021 FALHA -> REPOUSO only in a cycle where Clr_Erro=1 and no sensor fault is present; Clr_Erro SHALL otherwise be ignored.
REQ-022 Outputs SHALL be registered Moore outputs: Ve=1 iff ENCHENDO; Bomba=1 iff REGANDO; ERRO=1 iff FALHA; Al=1 iff FALHA or filtered level critical. All SHALL change in the same cycle Estado changes.
REQ-023 Ve and Bomba SHALL never both be 1.

Reset
REQ-024 While Rst_n=0 at a rising Clk edge: state REPOUSO, synchronizers, filtered bits and all counters 0; Ve, Bomba, Al, ERRO 0; Estado 0.
REQ-025 Reset asserted mid-fill or mid-irrigation SHALL force the reset values on the next edge and discard the timeout count.
REQ-026 First cycle after reset, filtered level is critical, so the block SHALL enter ENCHENDO with Al=1 on the following edge.

Configuration
REQ-027 With macro CAIXA_FILL_WATCHDOG_EN defined: a 16-bit counter clears on entry to ENCHENDO, increments each ENCHENDO cycle; reaching FILL_MAX with level not full SHALL force FALHA next edge.
REQ-028 Without CAIXA_FILL_WATCHDOG_EN: no counter is instantiated; ENCHENDO exits only on full level or sensor fault.

Structure
REQ-029 Package caixa_pkg SHALL hold the state enum, default DEB_CYCLES and FILL_MAX, and the level-decode constants.
REQ-030 Sub-module filtro_sensor (synchronizer + debounce, parameter DEB_CYCLES) SHALL be instantiated three times.

Verification (DEB_CYCLES=4, FILL_MAX=50)
REQ-031 Reset release, H=M=L=0 -> ENCHENDO 1 cycle after reset release, Ve=1, Al=1; raise L,M,H stepwise -> REPOUSO with Ve=0 exactly 6 cycles + 1 transition after H rises.
REQ-032 Level medium, Req_Rega=1 -> REGANDO, Bomba=1; drop M -> ENCHENDO, Bomba=0, Ve=1 same cycle.
REQ-033 Sensor glitch: L pulse of 3 cycles -> filtered L unchanged, no state change.
REQ-034 M=1, L=0 held -> FALHA, ERRO=1, Al=1; Clr_Erro while fault persists -> stays FALHA; clear sensors then Clr_Erro -> REPOUSO.
REQ-035 Watchdog build, L=1 only, held 50 cycles in ENCHENDO -> FALHA on next edge; non-watchdog build -> remains ENCHENDO indefinitely.
REQ-036 Rst_n=0 for one cycle during REGANDO -> all outputs 0, Estado=0 next edge.
